// File: rtl/bcd_scan_counter_pkg.sv
// Shared constants and the one-digit BCD step used by the scan counter.
package bcd_scan_counter_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam int unsigned BCD_MAX = 9;

  // One BCD digit step; returns {carry/borrow, next digit}.
  function automatic logic [BCD_W:0] bcd_step(input logic [BCD_W-1:0] dig,
                                              input logic             up);
    logic [BCD_W:0] res;
    res = '0;
    if (up) begin
      if (dig >= BCD_W'(BCD_MAX)) res = {1'b1, BCD_W'(0)};
      else                        res = {1'b0, dig + BCD_W'(1)};
    end else begin
      if (dig == BCD_W'(0))       res = {1'b1, BCD_W'(BCD_MAX)};
      else                        res = {1'b0, dig - BCD_W'(1)};
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_scan_counter_if.sv
// Control, count and scan-display signals of the BCD scan counter.
interface bcd_scan_counter_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  localparam int unsigned CNT_W = 4 * NUM_DIGITS;

  logic                  tick;
  logic                  en;
  logic                  up;
  logic                  load;
  logic [CNT_W-1:0]      load_val;
  logic                  lzb;
  logic [CNT_W-1:0]      count;
  logic [3:0]            bcd_out;
  logic [NUM_DIGITS-1:0] dig_sel;
  logic                  blank;
  logic                  wrap;
  logic                  load_err;

  modport master (
    output tick, en, up, load, load_val, lzb,
    input  count, bcd_out, dig_sel, blank, wrap, load_err
  );

  modport slave (
    input  tick, en, up, load, load_val, lzb,
    output count, bcd_out, dig_sel, blank, wrap, load_err
  );
endinterface

// File: rtl/bcd_scan_counter_bcd_digit.sv
// One BCD digit register with carry chain and validated synchronous load.
module bcd_digit
  import bcd_scan_counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [BCD_W-1:0] i_load_dig,
  input  logic             i_cin,
  input  logic             i_up,
  output logic [BCD_W-1:0] o_dig,
  output logic             o_carry_c,
  output logic             o_load_err_c
);

  logic [BCD_W-1:0] r_dig;
  logic [BCD_W:0]   w_step;
  logic             w_bad;

  // Next value if this digit steps, and validity of the load digit.
  always_comb begin
    w_step       = bcd_step(r_dig, i_up);
    w_bad        = (i_load_dig > BCD_W'(BCD_MAX));
    o_carry_c    = i_cin & w_step[BCD_W];
    o_load_err_c = i_load & w_bad;
  end

  // Digit register: load beats step; invalid load digits become 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dig <= '0;
    end else if (i_load) begin
      r_dig <= w_bad ? BCD_W'(0) : i_load_dig;
    end else if (i_cin) begin
      r_dig <= w_step[BCD_W-1:0];
    end
  end

  assign o_dig = r_dig;

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with time-multiplexed digit scan output.
module bcd_scan_counter
  import bcd_scan_counter_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 1000
) (
  input logic               clk,
  input logic               rst,
  bcd_scan_counter_if.slave bus
);

  localparam int unsigned CNT_W   = BCD_W * NUM_DIGITS;
  localparam int unsigned PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CNT_W-1:0]      w_count;
  logic [NUM_DIGITS-1:0] w_cin;
  logic [NUM_DIGITS-1:0] w_carry;
  logic [NUM_DIGITS-1:0] w_err;
  logic [NUM_DIGITS-1:0] w_blank_vec;
  logic                  w_zero;

  logic [PRESC_W-1:0]    r_presc;
  logic [IDX_W-1:0]      r_idx;
  logic [BCD_W-1:0]      r_bcd;
  logic [NUM_DIGITS-1:0] r_dig_sel;
  logic                  r_blank;
  logic                  r_wrap;
  logic                  r_load_err;

  // Count strobe enters digit 0 unless a load takes priority; carries ripple up.
  assign w_cin = {w_carry[NUM_DIGITS-2:0], bus.tick & bus.en & ~bus.load};

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .clk          (clk),
      .rst          (rst),
      .i_load       (bus.load),
      .i_load_dig   (bus.load_val[g*BCD_W +: BCD_W]),
      .i_cin        (w_cin[g]),
      .i_up         (bus.up),
      .o_dig        (w_count[g*BCD_W +: BCD_W]),
      .o_carry_c    (w_carry[g]),
      .o_load_err_c (w_err[g])
    );
  end

  // A digit is a leading zero if it and all more-significant digits are 0.
  always_comb begin
    w_blank_vec = '0;
    w_zero      = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_zero         = w_zero & (w_count[k*BCD_W +: BCD_W] == BCD_W'(0));
      w_blank_vec[k] = w_zero;
    end
  end

  // Wrap and load-error pulses, one cycle each.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= w_carry[NUM_DIGITS-1];
      r_load_err <= |w_err;
    end
  end

  // Free-running prescaler advancing the scanned digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PRESC_W'(SCAN_DIV - 1)) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? IDX_W'(0) : r_idx + IDX_W'(1);
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  // Scan outputs registered together so they always describe the same digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd     <= '0;
      r_dig_sel <= NUM_DIGITS'(1);
      r_blank   <= 1'b0;
    end else begin
      r_bcd     <= w_count[r_idx*BCD_W +: BCD_W];
      r_dig_sel <= NUM_DIGITS'(1) << r_idx;
      r_blank   <= bus.lzb & w_blank_vec[r_idx];
    end
  end

  assign bus.count    = w_count;
  assign bus.bcd_out  = r_bcd;
  assign bus.dig_sel  = r_dig_sel;
  assign bus.blank    = r_blank;
  assign bus.wrap     = r_wrap;
  assign bus.load_err = r_load_err;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter with NUM_DIGITS=4, SCAN_DIV=4.
module tb_bcd_scan_counter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  bcd_scan_counter_if #(.NUM_DIGITS(4)) bus ();

  bcd_scan_counter #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] val);
    bus.load     = 1'b1;
    bus.load_val = val;
    step();
    bus.load     = 1'b0;
  endtask

  task automatic do_tick(input logic up_v);
    bus.tick = 1'b1;
    bus.en   = 1'b1;
    bus.up   = up_v;
    step();
    bus.tick = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (bus.count !== 16'h0000 || bus.dig_sel !== 4'b0001 || bus.bcd_out !== 4'd0 ||
        bus.blank !== 1'b0 || bus.wrap !== 1'b0 || bus.load_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_init: count=%h sel=%b bcd=%h blank=%b wrap=%b lerr=%b",
               bus.count, bus.dig_sel, bus.bcd_out, bus.blank, bus.wrap, bus.load_err);
    end
    do_load(16'h1234);
    repeat (6) step();
    #3 rst = 1'b1;
    #1;
    total++;
    if (bus.count !== 16'h0000 || bus.dig_sel !== 4'b0001 || bus.bcd_out !== 4'd0 ||
        bus.wrap !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: count=%h sel=%b bcd=%h wrap=%b want 0000 0001 0 0",
               bus.count, bus.dig_sel, bus.bcd_out, bus.wrap);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      logic [3:0] exp_sel;
      step();
      exp_sel = (n <= 4) ? 4'b0001 : 4'b0010;
      total++;
      if (bus.dig_sel !== exp_sel) begin
        bad++;
        $display("FAIL reset_first_advance edge %0d: sel=%b want %b", n, bus.dig_sel, exp_sel);
      end
    end
  endtask

  task automatic test_up();
    bus.tick = 1'b1;
    bus.en   = 1'b1;
    bus.up   = 1'b1;
    repeat (10) step();
    bus.tick = 1'b0;
    total++;
    if (bus.count !== 16'h0010) begin
      bad++;
      $display("FAIL up_10_ticks: count=%h want 0010", bus.count);
    end
    do_load(16'h0999);
    do_tick(1'b1);
    total++;
    if (bus.count !== 16'h1000 || bus.wrap !== 1'b0) begin
      bad++;
      $display("FAIL up_carry: count=%h wrap=%b want 1000 0", bus.count, bus.wrap);
    end
    do_load(16'h9999);
    do_tick(1'b1);
    total++;
    if (bus.count !== 16'h0000 || bus.wrap !== 1'b1) begin
      bad++;
      $display("FAIL up_wrap: count=%h wrap=%b want 0000 1", bus.count, bus.wrap);
    end
    step();
    total++;
    if (bus.wrap !== 1'b0) begin
      bad++;
      $display("FAIL up_wrap_pulse: wrap=%b want 0", bus.wrap);
    end
  endtask

  task automatic test_down();
    do_load(16'h0000);
    do_tick(1'b0);
    total++;
    if (bus.count !== 16'h9999 || bus.wrap !== 1'b1) begin
      bad++;
      $display("FAIL down_wrap: count=%h wrap=%b want 9999 1", bus.count, bus.wrap);
    end
    step();
    total++;
    if (bus.wrap !== 1'b0) begin
      bad++;
      $display("FAIL down_wrap_pulse: wrap=%b want 0", bus.wrap);
    end
    do_load(16'h1000);
    do_tick(1'b0);
    total++;
    if (bus.count !== 16'h0999 || bus.wrap !== 1'b0) begin
      bad++;
      $display("FAIL down_borrow: count=%h wrap=%b want 0999 0", bus.count, bus.wrap);
    end
  endtask

  task automatic test_priority();
    bus.load     = 1'b1;
    bus.load_val = 16'h0042;
    bus.tick     = 1'b1;
    bus.en       = 1'b1;
    bus.up       = 1'b1;
    step();
    bus.load = 1'b0;
    bus.tick = 1'b0;
    total++;
    if (bus.count !== 16'h0042 || bus.wrap !== 1'b0 || bus.load_err !== 1'b0) begin
      bad++;
      $display("FAIL load_over_tick: count=%h wrap=%b lerr=%b want 0042 0 0",
               bus.count, bus.wrap, bus.load_err);
    end
    do_load(16'h00A5);
    total++;
    if (bus.count !== 16'h0005 || bus.load_err !== 1'b1) begin
      bad++;
      $display("FAIL load_invalid: count=%h lerr=%b want 0005 1", bus.count, bus.load_err);
    end
    step();
    total++;
    if (bus.load_err !== 1'b0) begin
      bad++;
      $display("FAIL load_err_pulse: lerr=%b want 0", bus.load_err);
    end
    bus.tick = 1'b1;
    bus.en   = 1'b0;
    step();
    bus.tick = 1'b0;
    bus.en   = 1'b1;
    step();
    total++;
    if (bus.count !== 16'h0005 || bus.wrap !== 1'b0) begin
      bad++;
      $display("FAIL tick_disabled: count=%h wrap=%b want 0005 0", bus.count, bus.wrap);
    end
  endtask

  task automatic test_scan();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.lzb      = 1'b0;
    bus.load     = 1'b1;
    bus.load_val = 16'h4321;
    for (int n = 1; n <= 36; n++) begin
      int         i;
      logic [3:0] exp_sel;
      logic [3:0] exp_bcd;
      step();
      if (n == 1) bus.load = 1'b0;
      if (n >= 2) begin
        i       = ((n - 1) / 4) % 4;
        exp_sel = 4'b0001 << i;
        exp_bcd = 4'(i + 1);
        total++;
        if (bus.dig_sel !== exp_sel || bus.bcd_out !== exp_bcd || bus.blank !== 1'b0 ||
            !$onehot(bus.dig_sel)) begin
          bad++;
          $display("FAIL scan edge %0d: sel=%b bcd=%h blank=%b want %b %h 0",
                   n, bus.dig_sel, bus.bcd_out, bus.blank, exp_sel, exp_bcd);
        end
      end
    end
  endtask

  task automatic blank_case(input logic [15:0] val, input logic lzb_v,
                            input logic [3:0] mask);
    do_load(val);
    bus.lzb = lzb_v;
    step();
    step();
    for (int n = 0; n < 16; n++) begin
      logic [3:0] exp_bcd;
      logic       exp_blank;
      int         i;
      i = 0;
      case (bus.dig_sel)
        4'b0001: i = 0;
        4'b0010: i = 1;
        4'b0100: i = 2;
        4'b1000: i = 3;
        default: i = -1;
      endcase
      total++;
      if (i < 0) begin
        bad++;
        $display("FAIL blank_sel_onehot val=%h: sel=%b", val, bus.dig_sel);
      end else begin
        exp_bcd   = val[i*4 +: 4];
        exp_blank = mask[i];
        if (bus.blank !== exp_blank || bus.bcd_out !== exp_bcd) begin
          bad++;
          $display("FAIL blank val=%h lzb=%b digit %0d: blank=%b bcd=%h want %b %h",
                   val, lzb_v, i, bus.blank, bus.bcd_out, exp_blank, exp_bcd);
        end
      end
      step();
    end
  endtask

  task automatic test_blank();
    blank_case(16'h0042, 1'b1, 4'b1100);
    blank_case(16'h0000, 1'b1, 4'b1110);
    blank_case(16'h0042, 1'b0, 4'b0000);
    blank_case(16'h1000, 1'b1, 4'b0000);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    bus.tick     = 1'b0;
    bus.en       = 1'b0;
    bus.up       = 1'b1;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.lzb      = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_up();
    test_down();
    test_priority();
    test_scan();
    test_blank();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
